// File: rtl/pipeline_ctrl_pkg.sv
// Shared constants for the pipeline register bank: forwarding selects,
// interrupt FSM encodings and the per-stage metadata layout.
package pipeline_ctrl_pkg;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_EXM = 2'b01;
  localparam logic [1:0] FWD_MWB = 2'b10;

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_ACK   = 2'd2;

  // Metadata is packed {we, load, rd, rs1, rs2}.
  localparam int unsigned META_FLAG_W = 2;

  function automatic int unsigned meta_width(input int unsigned reg_aw);
    return META_FLAG_W + 3 * reg_aw;
  endfunction

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Fetch-side instruction bus into the pipeline control block, plus the
// fetch enable it returns to the PC logic.
interface pipeline_ctrl_if #(
  parameter int unsigned REG_AW = 3
);
  logic              in_valid;
  logic              in_we;
  logic              in_load;
  logic [REG_AW-1:0] in_rd;
  logic [REG_AW-1:0] in_rs1;
  logic [REG_AW-1:0] in_rs2;
  logic              fetch_en;

  modport master (
    output in_valid, in_we, in_load, in_rd, in_rs1, in_rs2,
    input  fetch_en
  );

  modport slave (
    input  in_valid, in_we, in_load, in_rd, in_rs1, in_rs2,
    output fetch_en
  );
endinterface

// File: rtl/pipeline_ctrl_stage.sv
// One pipeline register: valid bit, metadata and payload with
// load / hold / bubble control. Bubble clears all three fields.
module pipe_stage_reg #(
  parameter int unsigned META_W = 11,
  parameter int unsigned DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              bubble,
  input  logic              d_valid,
  input  logic [META_W-1:0] d_meta,
  input  logic [DATA_W-1:0] d_payload,
  output logic              q_valid,
  output logic [META_W-1:0] q_meta,
  output logic [DATA_W-1:0] q_payload
);

  always_ff @(posedge clk) begin
    if (rst || bubble) begin
      q_valid   <= 1'b0;
      q_meta    <= '0;
      q_payload <= '0;
    end else if (load) begin
      q_valid   <= d_valid;
      q_meta    <= d_meta;
      q_payload <= d_payload;
    end
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline register bank and control: freeze, age-ordered flush, load-use
// bubble, EX operand forwarding selects and interrupt drain/acknowledge.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned STAGES = 4,
  parameter int unsigned DATA_W = 64,
  parameter int unsigned REG_AW = 3,
  parameter int unsigned SEL_W  = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  pipeline_ctrl_if.slave           fetch,
  input  logic [STAGES*DATA_W-1:0] stage_d,
  output logic [STAGES*DATA_W-1:0] stage_q,
  output logic [STAGES-1:0]        stage_valid,
  input  logic                     ext_stall,
  input  logic                     flush_req,
  input  logic [SEL_W-1:0]         flush_stage,
  input  logic                     irq,
  output logic                     irq_ack,
  output logic                     load_use,
  output logic [1:0]               fwd_sel1,
  output logic [1:0]               fwd_sel2
);

  localparam int unsigned META_W = meta_width(REG_AW);
  localparam int unsigned RS2_LO = 0;
  localparam int unsigned RS1_LO = REG_AW;
  localparam int unsigned RD_LO  = 2 * REG_AW;
  localparam int unsigned LD_BIT = 3 * REG_AW;
  localparam int unsigned WE_BIT = 3 * REG_AW + 1;

  logic [STAGES-1:0] valid_q;
  logic [STAGES-1:0] valid_d;
  logic [META_W-1:0] meta_q    [STAGES];
  logic [META_W-1:0] meta_d    [STAGES];
  logic [DATA_W-1:0] payload_q [STAGES];

  logic [1:0]  state_q;
  logic [1:0]  state_d;
  logic        fetch_en;
  int unsigned flush_lim;

  function automatic logic [1:0] fwd_pick(
    input logic [REG_AW-1:0] rs,
    input logic              v_exm,
    input logic [META_W-1:0] m_exm,
    input logic              v_mwb,
    input logic [META_W-1:0] m_mwb
  );
    if (v_exm && m_exm[WE_BIT] && (m_exm[RD_LO +: REG_AW] == rs)) return FWD_EXM;
    if (v_mwb && m_mwb[WE_BIT] && (m_mwb[RD_LO +: REG_AW] == rs)) return FWD_MWB;
    return FWD_RF;
  endfunction

  // Hazard and forwarding look only at registered state, so a frozen pipe
  // presents stable outputs regardless of the stall/flush inputs.
  assign load_use = valid_q[1] && meta_q[1][LD_BIT] && meta_q[1][WE_BIT] && valid_q[0] &&
                    ((meta_q[1][RD_LO +: REG_AW] == meta_q[0][RS1_LO +: REG_AW]) ||
                     (meta_q[1][RD_LO +: REG_AW] == meta_q[0][RS2_LO +: REG_AW]));

  assign fwd_sel1 = fwd_pick(meta_q[1][RS1_LO +: REG_AW], valid_q[2], meta_q[2], valid_q[3], meta_q[3]);
  assign fwd_sel2 = fwd_pick(meta_q[1][RS2_LO +: REG_AW], valid_q[2], meta_q[2], valid_q[3], meta_q[3]);

  assign fetch_en       = (state_q == ST_RUN) && !load_use;
  assign fetch.fetch_en = fetch_en;
  assign irq_ack        = (state_q == ST_ACK);
  assign stage_valid    = valid_q;

  always_comb begin
    flush_lim = 32'(flush_stage);
    if (flush_lim > STAGES - 1) flush_lim = STAGES - 1;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:   if (irq) state_d = ST_DRAIN;
      ST_DRAIN: if (valid_q == '0) state_d = ST_ACK;
      ST_ACK:   state_d = ST_RUN;
      default:  state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_RUN;
    else if (!ext_stall) state_q <= state_d;
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic ld;
    logic bb;

    if (k == 0) begin : g_head
      assign valid_d[k] = fetch.in_valid && fetch_en;
      assign meta_d[k]  = {fetch.in_we, fetch.in_load, fetch.in_rd, fetch.in_rs1, fetch.in_rs2};
    end else begin : g_body
      assign valid_d[k] = valid_q[k-1];
      assign meta_d[k]  = meta_q[k-1];
    end

    // Stages at or younger than the flushing stage bubble; older ones keep
    // advancing so the faulting instruction's predecessors retire.
    always_comb begin
      ld = 1'b0;
      bb = 1'b0;
      if (!ext_stall) begin
        if (flush_req) begin
          bb = (k <= flush_lim);
          ld = !(k <= flush_lim);
        end else if (load_use) begin
          bb = (k == 1);
          ld = (k > 1);
        end else begin
          ld = 1'b1;
        end
      end
    end

    pipe_stage_reg #(
      .META_W (META_W),
      .DATA_W (DATA_W)
    ) u_reg (
      .clk       (clk),
      .rst       (rst),
      .load      (ld),
      .bubble    (bb),
      .d_valid   (valid_d[k]),
      .d_meta    (meta_d[k]),
      .d_payload (stage_d[k*DATA_W +: DATA_W]),
      .q_valid   (valid_q[k]),
      .q_meta    (meta_q[k]),
      .q_payload (payload_q[k])
    );

    assign stage_q[k*DATA_W +: DATA_W] = payload_q[k];
  end

endmodule
